// File: rtl/apb_master.sv
// apb_master: single-outstanding APB initiator.
// Turns a valid/ready request into an APB SETUP/ACCESS transfer and returns
// the completion on a valid/ready response channel. A PREADY wait-state
// timeout stops a hung slave from stalling the bus.
//
// state  | meaning
// IDLE   | waiting for a request; req_ready_o high
// SETUP  | PSEL=1, PENABLE=0 for one cycle
// ACCESS | PSEL=1, PENABLE=1 until PREADY or timeout
// RESP   | response held on rsp_* until rsp_ready_i
module apb_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_write_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; a disabled timeout lets it wrap harmlessly.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] to_cnt;
  logic             xfer_done;
  logic             xfer_abort;
  logic             req_take;

  assign req_ready_o = (state == IDLE);
  assign req_take    = req_valid_i && req_ready_o;

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; normal completion takes priority over the timeout abort
  always_comb begin
    state_nxt  = state;
    xfer_done  = 1'b0;
    xfer_abort = 1'b0;
    case (state)
      IDLE:   if (req_take) state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          xfer_done = 1'b1;
          state_nxt = RESP;
        end else if (TO_EN && (to_cnt == TO_LAST)) begin
          xfer_abort = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP:   if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // APB strobes from flops; address/data/direction captured only on request acceptance
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
    end else begin
      PSEL    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      PENABLE <= (state_nxt == ACCESS);
      if (req_take) begin
        PADDR  <= req_addr_i;
        PWDATA <= req_wdata_i;
        PWRITE <= req_write_i;
      end
    end
  end

  // Wait-state counter: counts ACCESS cycles with PREADY low, cleared otherwise
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                      to_cnt <= '0;
    else if (state == ACCESS && !PREADY) to_cnt <= to_cnt + 1'b1;
    else                               to_cnt <= '0;
  end

  // Response capture; data and error are held while waiting for rsp_ready_i
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= (state_nxt == RESP);
      if (xfer_done) begin
        rsp_err_o   <= PSLVERR;
        rsp_rdata_o <= (PWRITE || PSLVERR) ? 32'h0 : PRDATA;
      end else if (xfer_abort) begin
        rsp_err_o   <= 1'b1;
        rsp_rdata_o <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed and randomized checks of apb_master with a
// transaction-level reference model and a memory-backed slave scoreboard.
module tb_apb_master;

  localparam int AW = 12;
  localparam int TO = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic          req_write_i = 1'b0;
  logic [31:0]   req_wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [31:0] mem [logic [AW-1:0]];

  apb_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Clock generation
  initial forever #5 HCLK = ~HCLK;

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
    cyc++;
  endtask

  // One full transfer: drive request, act as slave with 'waits' low-PREADY cycles,
  // hold the response for 'hold' cycles, then consume it.
  task automatic xfer(input logic [AW-1:0] a, input logic w, input logic [31:0] wd,
                      input int waits, input logic [31:0] rd, input logic se,
                      input int hold, input bit keep_valid);
    int          exp_acc;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          n;
    // Reference: a slave that never raises PREADY within TO ACCESS cycles is aborted
    if (waits >= TO) begin
      exp_acc = TO;
      exp_err = 1'b1;
      exp_rd  = 32'h0;
    end else begin
      exp_acc = waits + 1;
      exp_err = se;
      exp_rd  = (w || se) ? 32'h0 : rd;
    end
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_write_i = w;
    req_wdata_i = wd;
    check("req_ready_idle", 32'(req_ready_o), 32'h1);
    cyc = 0;
    tick();
    if (!keep_valid) req_valid_i = 1'b0;
    check("setup_psel", 32'(PSEL), 32'h1);
    check("setup_penable", 32'(PENABLE), 32'h0);
    check("setup_paddr", 32'(PADDR), 32'(a));
    check("setup_pwrite", 32'(PWRITE), 32'(w));
    if (w) check("setup_pwdata", PWDATA, wd);
    check("setup_req_ready", 32'(req_ready_o), 32'h0);
    tick();
    check("access_penable", 32'(PENABLE), 32'h1);
    n = 0;
    while (PSEL && PENABLE && n < 20) begin
      check("access_paddr", 32'(PADDR), 32'(a));
      check("access_pwrite", 32'(PWRITE), 32'(w));
      PREADY  = (n >= waits);
      PRDATA  = rd;
      PSLVERR = se;
      n++;
      tick();
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = $urandom;
    check("access_cycles", 32'(n), 32'(exp_acc));
    check("rsp_cycle", 32'(cyc), 32'(2 + exp_acc));
    check("rsp_valid", 32'(rsp_valid_o), 32'h1);
    check("rsp_psel", 32'(PSEL), 32'h0);
    check("rsp_penable", 32'(PENABLE), 32'h0);
    check("rsp_rdata", rsp_rdata_o, exp_rd);
    check("rsp_err", 32'(rsp_err_o), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      req_addr_i  = AW'($urandom);
      req_wdata_i = $urandom;
      tick();
      check("hold_valid", 32'(rsp_valid_o), 32'h1);
      check("hold_rdata", rsp_rdata_o, exp_rd);
      check("hold_err", 32'(rsp_err_o), 32'(exp_err));
      check("hold_req_ready", 32'(req_ready_o), 32'h0);
      check("hold_paddr", 32'(PADDR), 32'(a));
      check("hold_psel", 32'(PSEL), 32'h0);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("done_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("done_req_ready", 32'(req_ready_o), 32'h1);
    check("done_paddr_kept", 32'(PADDR), 32'(a));
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic          rw;
    logic [31:0]   rwd;
    logic [31:0]   rrd;
    logic          rse;
    int            rwaits;

    // Reset values
    #23;
    check("rst_psel", 32'(PSEL), 32'h0);
    check("rst_penable", 32'(PENABLE), 32'h0);
    check("rst_paddr", 32'(PADDR), 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_pwrite", 32'(PWRITE), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    check("rst_rsp_err", 32'(rsp_err_o), 32'h0);
    HRESETn = 1'b1;
    tick();
    check("post_rst_req_ready", 32'(req_ready_o), 32'h1);

    // Write then read, zero-wait slave
    xfer(12'h004, 1'b1, 32'h0000_0001, 0, 32'h0, 1'b0, 0, 1'b0);
    mem[12'h004] = 32'h0000_0001;
    xfer(12'h004, 1'b0, 32'h0, 0, mem[12'h004], 1'b0, 0, 1'b0);

    // Three wait states on a read
    xfer(12'h010, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);

    // Slave error on a read
    xfer(12'h020, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b1, 0, 1'b0);

    // Stuck slave: timeout after TO ACCESS cycles
    xfer(12'h030, 1'b0, 32'h0, 100, 32'hAAAA_5555, 1'b0, 0, 1'b0);

    // PREADY on the last allowed cycle completes normally
    xfer(12'h034, 1'b0, 32'h0, TO - 1, 32'h0BAD_F00D, 1'b0, 0, 1'b0);

    // Backpressure with a continuously valid request, then a back-to-back second request
    xfer(12'h040, 1'b1, 32'hCAFE_0001, 0, 32'h0, 1'b0, 5, 1'b1);
    mem[12'h040] = 32'hCAFE_0001;
    xfer(12'h040, 1'b0, 32'h0, 1, mem[12'h040], 1'b0, 0, 1'b0);

    // Async reset during ACCESS
    req_valid_i = 1'b1;
    req_addr_i  = 12'h0AC;
    req_write_i = 1'b1;
    req_wdata_i = 32'h5A5A_5A5A;
    tick();
    req_valid_i = 1'b0;
    tick();
    check("pre_rst_penable", 32'(PENABLE), 32'h1);
    #2;
    HRESETn = 1'b0;
    #1;
    check("async_psel", 32'(PSEL), 32'h0);
    check("async_penable", 32'(PENABLE), 32'h0);
    check("async_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("async_paddr", 32'(PADDR), 32'h0);
    check("async_pwdata", PWDATA, 32'h0);
    #10;
    HRESETn = 1'b1;
    tick();
    check("rerst_req_ready", 32'(req_ready_o), 32'h1);
    check("rerst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    xfer(12'h0AC, 1'b0, 32'h0, 0, 32'h7777_1111, 1'b0, 1, 1'b0);

    // Randomized transfers against the memory scoreboard
    for (int i = 0; i < 30; i++) begin
      ra     = AW'($urandom_range(0, 15) * 4);
      rw     = 1'($urandom_range(0, 1));
      rwd    = $urandom;
      rwaits = int'($urandom_range(0, 5));
      rse    = ($urandom_range(0, 5) == 0);
      rrd    = mem.exists(ra) ? mem[ra] : 32'h0;
      xfer(ra, rw, rwd, rwaits, rrd, rse, int'($urandom_range(0, 2)), 1'b0);
      if (rw && !rse && rwaits < TO) mem[ra] = rwd;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-outstanding APB initiator that converts a valid/ready request stream into APB SETUP/ACCESS transfers.
- Returns each completion on a valid/ready response channel.
- Drives the peripheral APB slaves (timer, GPIO, etc.) from the core-side interconnect.
- Includes a PREADY wait-state timeout so a hung slave cannot stall the bus.

Parameters:
- APB_ADDR_WIDTH, 12, width of request address and PADDR.
- TIMEOUT_CYCLES, 255, ACCESS-phase cycles without PREADY before abort; 0 disables the timeout.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_addr_i  in  APB_ADDR_WIDTH  byte address.
- req_write_i  in  1  1=write, 0=read.
- req_wdata_i  in  32  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when high with rsp_valid_o.
- rsp_rdata_o  out  32  read data; 0 for writes and errors.
- rsp_err_o  out  1  PSLVERR seen or timeout.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- Reset values: PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, timeout counter=0.
- req_ready_o = (state==IDLE); it is high from the first cycle after reset release.
- IDLE:
  - On req_valid_i && req_ready_o: register addr, write and wdata into PADDR, PWRITE, PWDATA.
  - Next cycle is SETUP.
  - Request inputs are ignored in every other state.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1; timeout counter increments each cycle PREADY=0.
  - PREADY=1: transfer completes this cycle.
    - rsp_rdata_o = PWRITE ? 0 : PRDATA.
    - rsp_err_o = PSLVERR.
    - If PSLVERR=1, rsp_rdata_o=0.
    - Next state RESP; counter cleared.
  - PREADY=0 and TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: abort.
    - rsp_err_o=1, rsp_rdata_o=0, next state RESP.
  - PREADY=1 in the same cycle as the timeout threshold: normal completion wins.
- RESP: PSEL=0, PENABLE=0; rsp_valid_o=1 with rdata and err held stable.
  - On rsp_ready_i: go to IDLE.
  - No new request is accepted until IDLE, so at most one transfer is in flight.
- PADDR, PWDATA and PWRITE are stable from SETUP through the end of ACCESS. They keep their last values after the transfer; no toggling while PSEL=0.
- PSEL and PENABLE come straight from flops, never combinational.
- Latency with a zero-wait slave:
  - Request accepted at cycle 0.
  - SETUP at cycle 1, ACCESS at cycle 2.
  - rsp_valid_o high at cycle 3.
  - Minimum 4 cycles per transfer including the return to IDLE.
- Each wait state adds 1 cycle.
- Async reset mid-transfer forces IDLE and the reset values immediately. The response is lost and no partial response is issued.

Test Plan:
- Write then read, zero-wait slave (PREADY=1, PSLVERR=0).
  - Stimulus: write addr 0x004 data 0x0000_0001; then read addr 0x004 with PRDATA=0x0000_0001.
  - Required: PSEL rises cycle 1, PENABLE rises cycle 2.
  - Required: write rsp at cycle 3 with err=0, rdata=0; read rsp rdata=0x0000_0001, err=0.
- Wait states: slave holds PREADY=0 for 3 ACCESS cycles, read data 0xDEAD_BEEF.
  - Required: PENABLE high 4 cycles, PADDR/PWRITE constant, rsp at cycle 6 with rdata=0xDEAD_BEEF.
- Slave error: read with PREADY=1, PSLVERR=1, PRDATA=0x1234_5678.
  - Required: rsp_err_o=1, rsp_rdata_o=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY stuck 0.
  - Required: exactly 4 ACCESS cycles, then PSEL=0, rsp_err_o=1, rdata=0.
  - Also drive PREADY=1 on the 4th cycle: required normal completion with err=0.
- Backpressure: rsp_ready_i=0 for 5 cycles while req_valid_i=1 continuously.
  - Required: rsp_valid_o stays high with stable data, req_ready_o=0 throughout.
  - Second request accepted only the cycle after rsp handshake + IDLE.
- Reset mid-ACCESS: assert HRESETn=0 during ACCESS.
  - Required: PSEL, PENABLE and rsp_valid_o go 0 asynchronously.
  - Required: after release, req_ready_o=1 and a new transfer completes normally.
